// File: rtl/zeroriscy_htif_pkg.sv
// Shared definitions for the zeroriscy host interface: MMIO addresses,
// verdict states and console status register layout.
package zeroriscy_htif_pkg;

  // Default MMIO map seen by the core data port
  localparam logic [31:0] HTIF_TOHOST0  = 32'h80001000;
  localparam logic [31:0] HTIF_TOHOST1  = 32'h80003000;
  localparam logic [31:0] HTIF_TOHOST2  = 32'h8013fffc;
  localparam logic [31:0] HTIF_CON_ADDR = 32'h9a100000;
  localparam logic [31:0] HTIF_CON_STAT = 32'h9a100004;

  // Verdict FSM: RUN until the program reports or runs out of cycles
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } verdict_e;

  // Console status word layout: {16'b0, level[7:0], 6'b0, full, empty}
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_MSB = 15;

endpackage

// File: rtl/zeroriscy_htif_fifo.sv
// Generic circular FIFO with an extra pointer MSB to tell full from empty.
// Pushes while full and pops while empty are dropped internally.
module zeroriscy_htif_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/zeroriscy_htif.sv
// Host-interface MMIO slave: tohost verdict latch, console byte FIFO with a
// valid/ready drain, status register and a free-running cycle counter.
module zeroriscy_htif
  import zeroriscy_htif_pkg::*;
#(
  parameter int          CON_DEPTH = 16,
  parameter logic [31:0] TOHOST0   = HTIF_TOHOST0,
  parameter logic [31:0] TOHOST1   = HTIF_TOHOST1,
  parameter logic [31:0] TOHOST2   = HTIF_TOHOST2,
  parameter logic [31:0] CON_ADDR  = HTIF_CON_ADDR,
  parameter logic [31:0] CON_STAT  = HTIF_CON_STAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        hit_o,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  input  logic [63:0] max_cycles_i,
  output logic [63:0] cycle_count_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] fail_code_o
);

  localparam int LVL_W = $clog2(CON_DEPTH) + 1;

  logic             is_tohost;
  logic             is_con;
  logic             is_stat;
  logic             con_wr;
  logic             gnt;
  logic             tohost_wr;
  logic             con_full;
  logic             con_empty;
  logic [LVL_W-1:0] con_level;
  logic [7:0]       level8;
  logic [7:0]       fifo_head;
  logic [31:0]      stat_word;
  logic             timeout_hit;

  logic             rvalid_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [63:0]      cycle_q;
  verdict_e         state_q;
  verdict_e         state_d;
  logic [30:0]      fail_code_q;
  logic [30:0]      fail_code_d;

  // Byte enables never matter here: console takes byte 0, tohost the full word
  logic             unused_be;
  assign unused_be = ^data_be_i;

  assign is_tohost = (data_addr_i == TOHOST0) || (data_addr_i == TOHOST1) ||
                     (data_addr_i == TOHOST2);
  assign is_con    = (data_addr_i == CON_ADDR);
  assign is_stat   = (data_addr_i == CON_STAT);

  assign hit_o     = data_req_i & (is_tohost | is_con | is_stat);
  assign con_wr    = hit_o & data_we_i & is_con;
  // A console write into a full FIFO is stalled by withholding the grant
  assign gnt       = hit_o & ~(con_wr & con_full);
  assign tohost_wr = gnt & data_we_i & is_tohost;

  assign data_gnt_o = gnt;

  zeroriscy_htif_fifo #(
    .WIDTH (8),
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (gnt & con_wr),
    .push_data (data_wdata_i[7:0]),
    .pop       (con_valid_o & con_ready_i),
    .head      (fifo_head),
    .full      (con_full),
    .empty     (con_empty),
    .level     (con_level)
  );

  assign con_valid_o = ~con_empty;
  assign con_data_o  = con_empty ? 8'h00 : fifo_head;
  assign level8      = 8'(con_level);

  // Assemble the console status word from the live FIFO flags
  always_comb begin
    stat_word = '0;
    stat_word[STAT_EMPTY_BIT] = con_empty;
    stat_word[STAT_FULL_BIT]  = con_full;
    stat_word[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level8;
  end

  // One-cycle response pipeline for every granted access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & data_we_i & is_stat;
      rdata_q  <= (gnt & ~data_we_i & is_stat) ? stat_word : 32'h0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;

  // Saturating cycle counter, keeps running after a verdict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else if (!(&cycle_q)) cycle_q <= cycle_q + 64'd1;
  end

  assign cycle_count_o = cycle_q;
  assign timeout_hit   = (max_cycles_i != 64'd0) && (cycle_q > max_cycles_i);

  // Verdict state and fail code registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  // Next verdict: a real tohost write beats a simultaneous timeout
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    if (state_q == ST_RUN) begin
      if (tohost_wr && (data_wdata_i != 32'd0)) begin
        if (data_wdata_i == 32'd1) begin
          state_d = ST_PASS;
        end else begin
          state_d     = ST_FAIL;
          fail_code_d = data_wdata_i[31:1];
        end
      end else if (timeout_hit) begin
        state_d = ST_TMO;
      end
    end
  end

  assign done_o      = (state_q != ST_RUN);
  assign pass_o      = (state_q == ST_PASS);
  assign timeout_o   = (state_q == ST_TMO);
  assign fail_code_o = fail_code_q;

endmodule
